// File: rtl/figure_pkg.sv
// figure_pkg -- shared definitions for the figure controller.
//   figure_state_t : controller state (IDLE, STAND, RISE, FALL)
//   SPRITE_W/H, SCALE : sprite geometry (26x26 source pixels drawn at 2x)
//   SCREEN_W/H : visible screen size in pixels
//   POS_W : width of the position registers fed to the sprite drawer
package figure_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STAND = 2'd1,
        ST_RISE  = 2'd2,
        ST_FALL  = 2'd3
    } figure_state_t;

    localparam int SPRITE_W = 26;
    localparam int SPRITE_H = 26;
    localparam int SCALE    = 2;
    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int POS_W    = 12;

endpackage

// File: rtl/btn_sync.sv
// btn_sync -- two-flop synchronizer for asynchronous level inputs.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset, clears both flop stages
//   async_in : WIDTH asynchronous level signals
//   sync_out : the same signals, two clk edges later, safe to use in clk domain
module btn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // One independent two-stage chain per bit; bits are never combined
    // before the second stage, so no cross-bit skew assumptions are made.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q[gi] <= 1'b0;
                sync_q[gi] <= 1'b0;
            end else begin
                meta_q[gi] <= meta_d[gi];
                sync_q[gi] <= sync_d[gi];
            end
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/figure_ctl.sv
// figure_ctl -- movement controller for the player figure sprite.
// Advances one step per frame: walks left/right, jumps (fixed-length rise
// followed by a fall until a platform is hit) and returns to the spawn
// point whenever the game is not running.
// Build option: define FIGURE_CTL_SCREEN_WRAP_EN to make the figure wrap
// around the horizontal screen edges instead of stopping at them.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   frame_tick         : one-cycle pulse per frame; state moves only then
//   btn_left/right/jump: asynchronous level buttons (synchronized inside)
//   on_ground          : platform below the figure, valid at frame_tick
//   start_game         : level, game running
//   rect_posx/posy     : registered top-left position of the figure
//   airborne           : registered, high while rising or falling
module figure_ctl
    import figure_pkg::*;
#(
    parameter int X_START     = 100,
    parameter int Y_START     = 600,
    parameter int X_MAX       = SCREEN_W - SPRITE_W * SCALE,
    parameter int Y_MAX       = SCREEN_H - SPRITE_H * SCALE,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 6,
    parameter int JUMP_FRAMES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_jump,
    input  logic              on_ground,
    input  logic              start_game,
    output logic [POS_W-1:0]  rect_posx,
    output logic [POS_W-1:0]  rect_posy,
    output logic              airborne
);

    localparam int CNT_W = (JUMP_FRAMES > 1) ? $clog2(JUMP_FRAMES) : 1;

    localparam logic [POS_W-1:0] X_SPAWN   = POS_W'(X_START);
    localparam logic [POS_W-1:0] Y_SPAWN   = POS_W'(Y_START);
    localparam logic [POS_W-1:0] X_LIMIT   = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIMIT   = POS_W'(Y_MAX);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(JUMP_FRAMES - 1);

    // ---------------- button synchronization ----------------
    logic [2:0] btn_raw;
    logic [2:0] btn_s;
    logic       left_s;
    logic       right_s;
    logic       jump_s;

    assign btn_raw = {btn_jump, btn_right, btn_left};

    btn_sync #(
        .WIDTH (3)
    ) u_btn_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (btn_raw),
        .sync_out (btn_s)
    );

    assign left_s  = btn_s[0];
    assign right_s = btn_s[1];
    assign jump_s  = btn_s[2];

    // ---------------- state ----------------
    figure_state_t    state_q, state_d;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             airborne_q, airborne_d;

    // ---------------- horizontal step ----------------
    // One extra bit on the intermediates so an underflow shows up as bit 12
    // and an overflow past X_MAX can be compared without truncation.
    logic [POS_W:0]   x_left_w;
    logic [POS_W:0]   x_right_w;
    logic [POS_W-1:0] x_step;

    always_comb begin
        x_left_w  = {1'b0, x_q} - (POS_W+1)'(STEP_X);
        x_right_w = {1'b0, x_q} + (POS_W+1)'(STEP_X);
        x_step    = x_q;
        if (left_s && !right_s) begin
            if (x_left_w[POS_W]) begin
`ifdef FIGURE_CTL_SCREEN_WRAP_EN
                x_step = X_LIMIT;
`else
                x_step = '0;
`endif
            end else begin
                x_step = x_left_w[POS_W-1:0];
            end
        end else if (right_s && !left_s) begin
            if (x_right_w > (POS_W+1)'(X_MAX)) begin
`ifdef FIGURE_CTL_SCREEN_WRAP_EN
                x_step = '0;
`else
                x_step = X_LIMIT;
`endif
            end else begin
                x_step = x_right_w[POS_W-1:0];
            end
        end
    end

    // ---------------- vertical step (always saturating) ----------------
    logic [POS_W:0]   y_down_w;
    logic [POS_W-1:0] y_up;
    logic [POS_W-1:0] y_down;

    always_comb begin
        y_down_w = {1'b0, y_q} + (POS_W+1)'(STEP_Y);
        y_up     = (y_q < POS_W'(STEP_Y)) ? '0 : (y_q - POS_W'(STEP_Y));
        y_down   = (y_down_w > (POS_W+1)'(Y_MAX)) ? Y_LIMIT : y_down_w[POS_W-1:0];
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;

        if (frame_tick) begin
            if (!start_game) begin
                state_d = ST_IDLE;
                x_d     = X_SPAWN;
                y_d     = Y_SPAWN;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_STAND;
                    end
                    ST_STAND: begin
                        x_d = x_step;
                        // The transition frame itself does not move Y, so the
                        // counter covers exactly JUMP_FRAMES rising steps.
                        if (jump_s) begin
                            state_d = ST_RISE;
                            cnt_d   = CNT_LOAD;
                        end else if (!on_ground) begin
                            state_d = ST_FALL;
                        end
                    end
                    ST_RISE: begin
                        x_d = x_step;
                        y_d = y_up;
                        if (cnt_q == '0) begin
                            state_d = ST_FALL;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    ST_FALL: begin
                        x_d = x_step;
                        if (on_ground) begin
                            state_d = ST_STAND;
                        end else begin
                            y_d = y_down;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        airborne_d = (state_d == ST_RISE) || (state_d == ST_FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= X_SPAWN;
            y_q        <= Y_SPAWN;
            cnt_q      <= '0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            airborne_q <= airborne_d;
        end
    end

    assign rect_posx = x_q;
    assign rect_posy = y_q;
    assign airborne  = airborne_q;

endmodule

// File: tb/tb_figure_ctl.sv
// tb_figure_ctl -- self-checking bench for figure_ctl.
// Directed steps plus a randomized phase, all compared against a
// frame-level behavioural model of the figure's movement rules.
module tb_figure_ctl;

    localparam int X_START = 100;
    localparam int Y_START = 600;
    localparam int X_MAX   = 972;
    localparam int Y_MAX   = 716;
    localparam int STEP_X  = 4;
    localparam int STEP_Y  = 6;
    localparam int JUMP_FR = 16;

    localparam int M_IDLE  = 0;
    localparam int M_STAND = 1;
    localparam int M_RISE  = 2;
    localparam int M_FALL  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic        on_ground = 1'b1;
    logic        start_game = 1'b0;
    logic [11:0] rect_posx;
    logic [11:0] rect_posy;
    logic        airborne;

    int checks = 0;
    int failures = 0;

    // behavioural model
    int mode;
    int mx;
    int my;
    int rise_left;

    figure_ctl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .on_ground  (on_ground),
        .start_game (start_game),
        .rect_posx  (rect_posx),
        .rect_posy  (rect_posy),
        .airborne   (airborne)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode      = M_IDLE;
        mx        = X_START;
        my        = Y_START;
        rise_left = 0;
    endtask

    task automatic model_hmove();
        int dir;
        int nx;
        dir = int'(btn_right) - int'(btn_left);
        if (dir != 0) begin
            nx = mx + STEP_X * dir;
`ifdef FIGURE_CTL_SCREEN_WRAP_EN
            if (nx < 0)          nx = X_MAX;
            else if (nx > X_MAX) nx = 0;
`else
            if (nx < 0)          nx = 0;
            else if (nx > X_MAX) nx = X_MAX;
`endif
            mx = nx;
        end
    endtask

    // One frame of the movement rules, using the input levels at the tick.
    task automatic model_frame();
        if (!start_game) begin
            model_reset();
        end else begin
            case (mode)
                M_IDLE: mode = M_STAND;
                M_STAND: begin
                    model_hmove();
                    if (btn_jump) begin
                        mode      = M_RISE;
                        rise_left = JUMP_FR;
                    end else if (!on_ground) begin
                        mode = M_FALL;
                    end
                end
                M_RISE: begin
                    model_hmove();
                    my = (my - STEP_Y < 0) ? 0 : my - STEP_Y;
                    rise_left--;
                    if (rise_left == 0) mode = M_FALL;
                end
                default: begin
                    model_hmove();
                    if (on_ground) mode = M_STAND;
                    else my = (my + STEP_Y > Y_MAX) ? Y_MAX : my + STEP_Y;
                end
            endcase
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".x"}, {20'd0, rect_posx}, mx);
        chk({tag, ".y"}, {20'd0, rect_posy}, my);
        chk({tag, ".air"}, {31'd0, airborne}, (mode == M_RISE || mode == M_FALL) ? 1 : 0);
    endtask

    // Inputs have been set at a negedge; give the synchronizer time, then
    // issue one frame_tick and check the outcome half a cycle later.
    task automatic frame(input string tag);
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        model_frame();
        @(negedge clk);
        frame_tick = 1'b0;
        chk_all(tag);
        $display("frame %-10s L=%0b R=%0b J=%0b G=%0b S=%0b -> x=%0d y=%0d air=%0b",
                 tag, btn_left, btn_right, btn_jump, on_ground, start_game,
                 rect_posx, rect_posy, airborne);
    endtask

    initial begin
        model_reset();

        // reset state
        #1 rst_n = 1'b0;
        #1 chk_all("reset");
        repeat (3) @(negedge clk);
        chk_all("reset_held");
        rst_n = 1'b1;

        // idle without start_game stays put
        start_game = 1'b0;
        frame("idle");

        // start
        start_game = 1'b1;
        on_ground  = 1'b1;
        frame("start");

        // walk right 3 frames, then both buttons
        btn_right = 1'b1;
        for (int i = 0; i < 3; i++) frame("right");
        chk("right3_x", {20'd0, rect_posx}, 112);
        btn_left = 1'b1;
        for (int i = 0; i < 2; i++) frame("both");
        btn_left  = 1'b0;
        btn_right = 1'b0;

        // jump: one frame of jump, then no ground
        btn_jump = 1'b1;
        frame("jump");
        btn_jump  = 1'b0;
        on_ground = 1'b0;
        for (int i = 0; i < JUMP_FR; i++) frame("rise");
        chk("apex_y", {20'd0, rect_posy}, 504);
        btn_jump = 1'b1;  // ignored while falling
        for (int i = 0; i < 3; i++) frame("fall");
        btn_jump = 1'b0;
        on_ground = 1'b1;
        frame("land");
        chk("land_air", {31'd0, airborne}, 0);

        // walk to the left edge and past it
        btn_left = 1'b1;
        for (int i = 0; i < 29; i++) frame("left");
        btn_left = 1'b0;
        frame("edge_hold");

        // walk right across the whole screen and past the right edge
        btn_right = 1'b1;
        for (int i = 0; i < 250; i++) frame("right_run");
        btn_right = 1'b0;

        // reset during rise at frame 5
        btn_jump = 1'b1;
        frame("jump2");
        btn_jump  = 1'b0;
        on_ground = 1'b0;
        for (int i = 0; i < 5; i++) frame("rise2");
        rst_n = 1'b0;
        model_reset();
        #1 chk_all("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_tick = 1'b0;
        start_game = 1'b0;
        frame("post_rst");
        start_game = 1'b1;
        frame("restart");

        // start_game dropped during fall
        on_ground = 1'b0;
        frame("to_fall");
        frame("fall3");
        start_game = 1'b0;
        frame("drop");
        start_game = 1'b1;
        on_ground  = 1'b1;
        frame("restart2");

        // randomized frames
        for (int i = 0; i < 400; i++) begin
            btn_left   = 1'($urandom_range(0, 1));
            btn_right  = 1'($urandom_range(0, 1));
            btn_jump   = ($urandom_range(0, 7) == 0);
            on_ground  = ($urandom_range(0, 3) != 0);
            start_game = ($urandom_range(0, 31) != 0);
            frame("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
